wb_drain_buffer: RTL and testbench

- Write-back buffer directly downstream of the MESI cache controller.
- Accepts dirty-line write-backs (address + data) produced when a MODIFIED line is downgraded, queues them in order, and drains them to main memory over a valid/ready write port.
- Coalesces repeat write-backs to the same address.
- Provides a same-cycle lookup port so a read miss can be served from pending write-back data rather than from stale memory.

---
 rtl/wb_drain_buffer.sv | 125 ++++++++++++
 tb/tb_wb_drain_buffer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_drain_buffer.sv
// In-order write-back drain buffer: coalesces repeat write-backs to non-head entries and serves same-cycle lookups.
// Latency 1 cycle from push to mem_wr_valid; wb_ready = !full || coalesce hit (independent of mem_wr_ready).
module wb_drain_buffer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wb_valid,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  wb_ready,
  output logic                  mem_wr_valid,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic                  mem_wr_ready,
  input  logic                  lk_valid,
  input  logic [ADDR_WIDTH-1:0] lk_addr,
  output logic                  lk_hit,
  output logic [DATA_WIDTH-1:0] lk_data,
  output logic                  full,
  output logic                  empty,
  output logic [CNT_WIDTH-1:0]  coalesce_cnt,
  output logic [CNT_WIDTH-1:0]  drain_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]      r_vld;
  logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic [PW-1:0]         r_head;
  logic [PW-1:0]         r_tail;
  logic [CW-1:0]         r_count;
  logic [CNT_WIDTH-1:0]  r_coal_cnt;
  logic [CNT_WIDTH-1:0]  r_drain_cnt;

  logic          w_coal_hit;
  logic [PW-1:0] w_coal_idx;
  logic [PW-1:0] w_lk_idx;
  logic          w_push;
  logic          w_alloc;
  logic          w_pop;

  // The head is locked for the memory port, so a head match must allocate instead.
  always_comb begin
    w_coal_hit = 1'b0;
    w_coal_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (wb_valid && r_vld[i] && (PW'(i) != r_head) && (r_addr[i] == wb_addr)) begin
        w_coal_hit = 1'b1;
        w_coal_idx = PW'(i);
      end
    end
  end

  assign full         = (r_count == CW'(DEPTH));
  assign empty        = (r_count == '0);
  assign wb_ready     = !full || w_coal_hit;
  assign w_push       = wb_valid && wb_ready;
  assign w_alloc      = w_push && !w_coal_hit;
  assign mem_wr_valid = !empty;
  assign w_pop        = mem_wr_valid && mem_wr_ready;
  assign mem_wr_addr  = mem_wr_valid ? r_addr[r_head] : '0;
  assign mem_wr_data  = mem_wr_valid ? r_data[r_head] : '0;
  assign coalesce_cnt = r_coal_cnt;
  assign drain_cnt    = r_drain_cnt;

  // Walk from head towards tail so the youngest match wins.
  always_comb begin
    lk_hit   = 1'b0;
    lk_data  = '0;
    w_lk_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_lk_idx = r_head + PW'(k);
      if (lk_valid && r_vld[w_lk_idx] && (r_addr[w_lk_idx] == lk_addr)) begin
        lk_hit  = 1'b1;
        lk_data = r_data[w_lk_idx];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld       <= '0;
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_coal_cnt  <= '0;
      r_drain_cnt <= '0;
    end else begin
      if (w_pop) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= r_head + 1'b1;
      end
      if (w_alloc) begin
        r_vld[r_tail] <= 1'b1;
        r_tail        <= r_tail + 1'b1;
      end
      case ({w_alloc, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_push && w_coal_hit && (r_coal_cnt != '1))
        r_coal_cnt <= r_coal_cnt + 1'b1;
      if (w_pop && (r_drain_cnt != '1))
        r_drain_cnt <= r_drain_cnt + 1'b1;
    end
  end

  // Payload storage needs no reset: every read is qualified by r_vld.
  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_addr[r_tail] <= wb_addr;
      r_data[r_tail] <= wb_data;
    end else if (w_push) begin
      r_data[w_coal_idx] <= wb_data;
    end
  end

endmodule

// File: tb/tb_wb_drain_buffer.sv
// Directed bench for wb_drain_buffer: cycle table plus hand sequences for wrap, saturation and mid-drain reset.
module tb_wb_drain_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid;
  logic [31:0] wb_addr;
  logic [31:0] wb_data;
  logic        wb_ready;
  logic        mem_wr_valid;
  logic [31:0] mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic        mem_wr_ready;
  logic        lk_valid;
  logic [31:0] lk_addr;
  logic        lk_hit;
  logic [31:0] lk_data;
  logic        full;
  logic        empty;
  logic [3:0]  coalesce_cnt;
  logic [3:0]  drain_cnt;

  always #5 clk = ~clk;

  wb_drain_buffer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ready(wb_ready),
    .mem_wr_valid(mem_wr_valid), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_ready(mem_wr_ready),
    .lk_valid(lk_valid), .lk_addr(lk_addr), .lk_hit(lk_hit), .lk_data(lk_data),
    .full(full), .empty(empty), .coalesce_cnt(coalesce_cnt), .drain_cnt(drain_cnt)
  );

  typedef struct {
    logic        wv;
    logic [31:0] wa;
    logic [31:0] wd;
    logic        rdy;
    logic        lv;
    logic [31:0] la;
    logic        wr;
    logic        mv;
    logic [31:0] ma;
    logic [31:0] md;
    logic        lh;
    logic [31:0] ld;
    logic        fu;
    logic        em;
    logic [3:0]  cc;
    logic [3:0]  dc;
  } vec_t;

  vec_t        tv_q[$];
  logic [63:0] mon_q[$];
  logic [63:0] exp_q[$];
  logic        mon_en = 1'b0;
  int          n_chk  = 0;
  int          n_fail = 0;

  always @(negedge clk)
    if (mon_en && rst_n && mem_wr_valid && mem_wr_ready)
      mon_q.push_back({mem_wr_addr, mem_wr_data});

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tv(input logic [31:0] wv, wa, wd, rdy, lv, la,
                    input logic [31:0] wr, mv, ma, md, lh, ld, fu, em, cc, dc);
    vec_t v;
    v.wv = wv[0]; v.wa = wa; v.wd = wd; v.rdy = rdy[0]; v.lv = lv[0]; v.la = la;
    v.wr = wr[0]; v.mv = mv[0]; v.ma = ma; v.md = md; v.lh = lh[0]; v.ld = ld;
    v.fu = fu[0]; v.em = em[0]; v.cc = cc[3:0]; v.dc = dc[3:0];
    tv_q.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int guard;
    rst_n = 1'b0; wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
    mem_wr_ready = 1'b0; lk_valid = 1'b0; lk_addr = '0;

    //  wv wa      wd          rdy lv la     wr mv ma      md          lh ld     fu em cc dc
    tv(1, 'h40,  'hDEADBEEF, 1, 0, 0,     1, 0, 0,      0,          0, 0,     0, 1, 0, 0);
    tv(0, 0,     0,          1, 0, 0,     1, 1, 'h40,  'hDEADBEEF, 0, 0,     0, 0, 0, 0);
    tv(0, 0,     0,          0, 0, 0,     1, 0, 0,      0,          0, 0,     0, 1, 0, 1);
    tv(1, 'h10,  'h1,        0, 0, 0,     1, 0, 0,      0,          0, 0,     0, 1, 0, 1);
    tv(1, 'h20,  'h2,        0, 0, 0,     1, 1, 'h10,  'h1,        0, 0,     0, 0, 0, 1);
    tv(1, 'h30,  'h3,        0, 0, 0,     1, 1, 'h10,  'h1,        0, 0,     0, 0, 0, 1);
    tv(1, 'h40,  'h4,        0, 0, 0,     1, 1, 'h10,  'h1,        0, 0,     0, 0, 0, 1);
    tv(1, 'h50,  'h5,        0, 0, 0,     0, 1, 'h10,  'h1,        0, 0,     1, 0, 0, 1);
    tv(1, 'h30,  'h5,        0, 1, 'h30,  1, 1, 'h10,  'h1,        1, 'h3,   1, 0, 0, 1);
    tv(0, 0,     0,          1, 1, 'h30,  0, 1, 'h10,  'h1,        1, 'h5,   1, 0, 1, 1);
    tv(0, 0,     0,          1, 0, 0,     1, 1, 'h20,  'h2,        0, 0,     0, 0, 1, 2);
    tv(0, 0,     0,          1, 0, 0,     1, 1, 'h30,  'h5,        0, 0,     0, 0, 1, 3);
    tv(0, 0,     0,          1, 0, 0,     1, 1, 'h40,  'h4,        0, 0,     0, 0, 1, 4);
    tv(0, 0,     0,          0, 0, 0,     1, 0, 0,      0,          0, 0,     0, 1, 1, 5);
    tv(1, 'h10,  'h1,        0, 0, 0,     1, 0, 0,      0,          0, 0,     0, 1, 1, 5);
    tv(1, 'h10,  'h2,        0, 0, 0,     1, 1, 'h10,  'h1,        0, 0,     0, 0, 1, 5);
    tv(0, 0,     0,          0, 1, 'h10,  1, 1, 'h10,  'h1,        1, 'h2,   0, 0, 1, 5);
    tv(0, 0,     0,          1, 1, 'h10,  1, 1, 'h10,  'h1,        1, 'h2,   0, 0, 1, 5);
    tv(0, 0,     0,          1, 1, 'h10,  1, 1, 'h10,  'h2,        1, 'h2,   0, 0, 1, 6);
    tv(0, 0,     0,          0, 1, 'h10,  1, 0, 0,      0,          0, 0,     0, 1, 1, 7);
    tv(1, 'h20,  'hA,        0, 0, 0,     1, 0, 0,      0,          0, 0,     0, 1, 1, 7);
    tv(1, 'h20,  'hB,        0, 1, 'h20,  1, 1, 'h20,  'hA,        1, 'hA,   0, 0, 1, 7);
    tv(0, 0,     0,          0, 1, 'h20,  1, 1, 'h20,  'hA,        1, 'hB,   0, 0, 1, 7);
    tv(0, 0,     0,          1, 1, 'h99,  1, 1, 'h20,  'hA,        0, 0,     0, 0, 1, 7);
    tv(0, 0,     0,          1, 0, 'h20,  1, 1, 'h20,  'hB,        0, 0,     0, 0, 1, 8);
    tv(0, 0,     0,          0, 0, 0,     1, 0, 0,      0,          0, 0,     0, 1, 1, 9);
    tv(1, 'h100, 'h100,      0, 0, 0,     1, 0, 0,      0,          0, 0,     0, 1, 1, 9);
    tv(1, 'h110, 'h110,      0, 0, 0,     1, 1, 'h100, 'h100,      0, 0,     0, 0, 1, 9);
    tv(1, 'h120, 'h120,      0, 0, 0,     1, 1, 'h100, 'h100,      0, 0,     0, 0, 1, 9);
    tv(1, 'h130, 'h130,      0, 0, 0,     1, 1, 'h100, 'h100,      0, 0,     0, 0, 1, 9);
    tv(1, 'h140, 'h140,      1, 0, 0,     0, 1, 'h100, 'h100,      0, 0,     1, 0, 1, 9);
    tv(1, 'h140, 'h140,      0, 0, 0,     1, 1, 'h110, 'h110,      0, 0,     0, 0, 1, 10);
    tv(0, 0,     0,          0, 0, 0,     0, 1, 'h110, 'h110,      0, 0,     1, 0, 1, 10);
    tv(1, 'h120, 'hEE,       1, 0, 0,     1, 1, 'h110, 'h110,      0, 0,     1, 0, 1, 10);
    tv(0, 0,     0,          0, 0, 0,     1, 1, 'h120, 'hEE,       0, 0,     0, 0, 2, 11);

    #12;
    chk("rst mem_wr_valid", 64'(mem_wr_valid), 64'(0));
    chk("rst mem_wr_addr",  64'(mem_wr_addr),  64'(0));
    chk("rst mem_wr_data",  64'(mem_wr_data),  64'(0));
    chk("rst lk_hit",       64'(lk_hit),       64'(0));
    chk("rst lk_data",      64'(lk_data),      64'(0));
    chk("rst full",         64'(full),         64'(0));
    chk("rst empty",        64'(empty),        64'(1));
    chk("rst wb_ready",     64'(wb_ready),     64'(1));
    chk("rst coalesce_cnt", 64'(coalesce_cnt), 64'(0));
    chk("rst drain_cnt",    64'(drain_cnt),    64'(0));
    #1 rst_n = 1'b1;
    tick();

    foreach (tv_q[i]) begin
      wb_valid = tv_q[i].wv; wb_addr = tv_q[i].wa; wb_data = tv_q[i].wd;
      mem_wr_ready = tv_q[i].rdy; lk_valid = tv_q[i].lv; lk_addr = tv_q[i].la;
      #1;
      chk($sformatf("row%0d wb_ready", i),     64'(wb_ready),     64'(tv_q[i].wr));
      chk($sformatf("row%0d mem_wr_valid", i), 64'(mem_wr_valid), 64'(tv_q[i].mv));
      chk($sformatf("row%0d mem_wr_addr", i),  64'(mem_wr_addr),  64'(tv_q[i].ma));
      chk($sformatf("row%0d mem_wr_data", i),  64'(mem_wr_data),  64'(tv_q[i].md));
      chk($sformatf("row%0d lk_hit", i),       64'(lk_hit),       64'(tv_q[i].lh));
      chk($sformatf("row%0d lk_data", i),      64'(lk_data),      64'(tv_q[i].ld));
      chk($sformatf("row%0d full", i),         64'(full),         64'(tv_q[i].fu));
      chk($sformatf("row%0d empty", i),        64'(empty),        64'(tv_q[i].em));
      chk($sformatf("row%0d coalesce_cnt", i), 64'(coalesce_cnt), 64'(tv_q[i].cc));
      chk($sformatf("row%0d drain_cnt", i),    64'(drain_cnt),    64'(tv_q[i].dc));
      tick();
    end

    // Pointer wrap: 12 more distinct pushes behind the three leftover entries.
    lk_valid = 1'b0;
    exp_q.push_back({32'h120, 32'hEE});
    exp_q.push_back({32'h130, 32'h130});
    exp_q.push_back({32'h140, 32'h140});
    mon_q.delete();
    mon_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      wb_valid = 1'b1; wb_addr = 32'h1000 + 32'(i); wb_data = 32'hC000 + 32'(i);
      mem_wr_ready = ((i % 3) != 0);
      exp_q.push_back({wb_addr, wb_data});
      #1;
      guard = 0;
      while (!wb_ready && guard < 20) begin
        tick();
        guard++;
      end
      if (guard >= 20) chk($sformatf("wrap push%0d timeout", i), 64'(guard), 64'(0));
      tick();
    end
    wb_valid = 1'b0; mem_wr_ready = 1'b1;
    guard = 0;
    while (!empty && guard < 40) begin
      tick();
      guard++;
    end
    chk("wrap drain timeout", 64'(guard >= 40), 64'(0));
    #6;
    mon_en = 1'b0;
    chk("wrap drained count", 64'(mon_q.size()), 64'(exp_q.size()));
    foreach (exp_q[i])
      chk($sformatf("wrap order%0d", i), (i < mon_q.size()) ? mon_q[i] : 64'hX, exp_q[i]);
    chk("drain_cnt saturates", 64'(drain_cnt), 64'(15));
    tick();

    // Reset while three entries are pending and the head is presented.
    mem_wr_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      wb_valid = 1'b1; wb_addr = 32'h200 + 32'(j); wb_data = 32'h300 + 32'(j);
      tick();
    end
    wb_valid = 1'b0;
    #1;
    chk("pre-rst mem_wr_valid", 64'(mem_wr_valid), 64'(1));
    chk("pre-rst mem_wr_addr",  64'(mem_wr_addr),  64'(32'h200));
    rst_n = 1'b0;
    #1;
    chk("mid-rst mem_wr_valid", 64'(mem_wr_valid), 64'(0));
    chk("mid-rst empty",        64'(empty),        64'(1));
    chk("mid-rst coalesce_cnt", 64'(coalesce_cnt), 64'(0));
    chk("mid-rst drain_cnt",    64'(drain_cnt),    64'(0));
    #1 rst_n = 1'b1;
    tick();
    chk("post-rst no reissue", 64'(mem_wr_valid), 64'(0));
    mon_q.delete();
    mon_en = 1'b1;
    wb_valid = 1'b1; wb_addr = 32'h77; wb_data = 32'h7777; mem_wr_ready = 1'b1;
    tick();
    wb_valid = 1'b0;
    #1;
    chk("post-rst mem_wr_valid", 64'(mem_wr_valid), 64'(1));
    chk("post-rst mem_wr_addr",  64'(mem_wr_addr),  64'(32'h77));
    chk("post-rst mem_wr_data",  64'(mem_wr_data),  64'(32'h7777));
    tick();
    #1;
    mon_en = 1'b0;
    chk("post-rst empty",     64'(empty),        64'(1));
    chk("post-rst drain_cnt", 64'(drain_cnt),    64'(1));
    chk("post-rst mem writes", 64'(mon_q.size()), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
